layer_argmax_8_16: RTL
======================

// Module: layer_argmax_8_16
// PURPOSE
//   Downstream classifier stage for layer_8_10_1_16. Consumes the layer's output
//   stream as consecutive M-element vectors of signed T-bit values. Emits one
//   result word per vector: the index and value of the largest element.
//   Holds one pending result so that the next vector can stream in while the
//   consumer is stalled.
// PARAMETERS
//   M     8    elements per vector (layer output count); M >= 2
//   T     16   element width in bits, signed two's complement
//   IDXW  $clog2(M)  localparam, width of the index field
// PORTS
//   clk      in   1     single clock; all state changes on rising edge
//   reset    in   1     asynchronous, active-low (0 = reset)
//   s_valid  in   1     upstream element valid (driven by layer m_valid)
//   s_ready  out  1     element accepted when s_valid && s_ready
//   data_in  in   T     signed element (driven by layer data_out)
//   m_valid  out  1     result valid
//   m_ready  in   1     result taken when m_valid && m_ready
//   m_index  out  IDXW  position 0..M-1 of the maximum within the vector
//   m_max    out  T     signed maximum value
// BEHAVIOUR
//   Reset (reset==0, async): cnt=0, run_max=0, run_idx=0, m_valid=0, m_index=0,
//     m_max=0, s_ready=0. After release, s_ready=1 on the first clock.
//   State: element counter cnt (0..M-1), running max run_max/run_idx, output regs.
//   Accept (s_valid && s_ready):
//     - cnt==0: run_max<=data_in, run_idx<=0, cnt<=1.
//     - 0<cnt<M-1: if $signed(data_in) > run_max, then run_max<=data_in and
//       run_idx<=cnt; cnt<=cnt+1.
//     - cnt==M-1: final = (data_in > run_max) ? {M-1,data_in} : {run_idx,run_max};
//       m_index/m_max<=final, m_valid<=1, cnt<=0 (wrap).
//   Ties: the comparison is strictly greater, so the lowest index wins.
//   Latency: m_valid rises on the clock edge that accepts element M-1.
//     The result is visible in the cycle that follows.
//   s_ready = !(cnt==M-1 && m_valid && !m_ready). Elements 0..M-2 are always
//     accepted. The last element stalls only while a prior result is unread.
//     s_ready is combinational from cnt, m_valid and m_ready; it never depends
//     on s_valid.
//   Output hold: while m_valid && !m_ready, m_index and m_max stay stable.
//   Simultaneous events: if a result is taken and element M-1 is accepted in the
//     same cycle, the registers load the new result and m_valid stays 1.
//   Result taken with no new result: m_valid<=0 and the registers keep their value.
//   Throughput: one vector per M cycles with a continuous s_valid and m_ready.
//   Reset mid-vector: the partial vector is discarded. The first element after
//     release is element 0 of a new vector.
//   Comparison and storage are full T-bit signed; no saturation or truncation.
// TESTING
//   1) Vector {3,-1,7,7,0,2,-5,1}, m_ready=1 -> m_index=2, m_max=7 (tie goes to
//      the lower index); m_valid is high for exactly 1 cycle.
//   2) Vector {-8,-3,-20,-3,-32768,-9,-4,-100} -> m_index=1, m_max=16'hFFFD.
//   3) Last element max {0,0,0,0,0,0,0,32767} -> m_index=7, m_max=16'h7FFF.
//   4) Two vectors back-to-back with m_ready=0: element 7 of vector 2 sees
//      s_ready=0 and result 1 stays stable. Raise m_ready -> result 1 is taken;
//      element 7 is accepted in the same cycle; result 2 appears; no gap.
//   5) Reset low after 4 elements {100,...}, then the vector {1,2,3,4,5,6,7,8}
//      -> m_index=7, m_max=8; m_valid=0 throughout reset.
//   6) Random s_valid/m_ready over 1000 vectors against a reference model
//      -> zero mismatches and no lost or duplicated results.

Source files
------------

// File: rtl/layer_argmax_8_16.sv
// Streaming argmax over consecutive M-element signed vectors.
// Emits {index, value} of the largest element per vector and holds one pending result.
module layer_argmax_8_16 #(
  parameter int unsigned M = 8,
  parameter int unsigned T = 16,
  localparam int unsigned IDXW = $clog2(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [T-1:0]    data_in,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [IDXW-1:0] m_index,
  output logic [T-1:0]    m_max
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(M - 1);

  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [T-1:0]    run_max_q, run_max_d;
  logic [IDXW-1:0] run_idx_q, run_idx_d;
  logic            m_valid_q, m_valid_d;
  logic [IDXW-1:0] m_index_q, m_index_d;
  logic [T-1:0]    m_max_q, m_max_d;
  logic            live_q;

  logic cnt_last;
  logic accept;
  logic take;
  logic greater;

  // live_q keeps s_ready low until the first clock after reset release
  assign cnt_last = (cnt_q == LAST_IDX);
  assign s_ready  = live_q && !(cnt_last && m_valid_q && !m_ready);
  assign accept   = s_valid && s_ready;
  assign take     = m_valid_q && m_ready;
  assign greater  = $signed(data_in) > $signed(run_max_q);

  assign m_valid = m_valid_q;
  assign m_index = m_index_q;
  assign m_max   = m_max_q;

  always_comb begin
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    m_valid_d = m_valid_q;
    m_index_d = m_index_q;
    m_max_d   = m_max_q;

    if (take) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      if (cnt_q == '0) begin
        run_max_d = data_in;
        run_idx_d = '0;
        cnt_d     = IDXW'(1);
      end else if (!cnt_last) begin
        if (greater) begin
          run_max_d = data_in;
          run_idx_d = cnt_q;
        end
        cnt_d = cnt_q + IDXW'(1);
      end else begin
        // Strict compare keeps the lowest index on ties
        m_index_d = greater ? LAST_IDX : run_idx_q;
        m_max_d   = greater ? data_in : run_max_q;
        m_valid_d = 1'b1;
        cnt_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      m_valid_q <= 1'b0;
      m_index_q <= '0;
      m_max_q   <= '0;
      live_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      m_valid_q <= m_valid_d;
      m_index_q <= m_index_d;
      m_max_q   <= m_max_d;
      live_q    <= 1'b1;
    end
  end

endmodule
